rr_arbiter_8: RTL
=================

Name: rr_arbiter_8

Overview:
- Round-robin arbiter sharing one resource among 8 requesters.
- Registered winner index (3 bits) is decoded to a one-hot 8-bit grant, the same encoding as the 3-to-8 decoder.
- Sits between requesting agents and a shared resource (bus, memory port).
- Grant is held until the owner drops its request; an optional preemption timer bounds hold time.

Parameters:
- MAX_HOLD, default 16: max consecutive grant cycles for one owner before preemption (used only with ARB_TIMEOUT_EN); legal range 2..255.
- HOLD_W, default 8: width of the hold counter; must satisfy MAX_HOLD <= 2^HOLD_W - 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- req  input  8  request vector; bit i = requester i; level-sensitive.
- gnt  output  8  one-hot grant; all zero when no owner.
- gnt_idx  output  3  binary index of owner; 0 when idle.
- gnt_valid  output  1  high while any grant is active; equals OR of gnt.
- preempt  output  1  one-cycle pulse in the cycle a timeout-forced handover takes effect.

Behaviour:
- All outputs are registered. Reset (rst_n=0 at clk edge) gives gnt=0, gnt_idx=0, gnt_valid=0, preempt=0, state=IDLE, ptr=0, hold_cnt=0.
- Reset mid-grant drops the grant in the next cycle, with no handover.
- Invariant: gnt == decode(gnt_idx) when gnt_valid=1, else gnt == 0.
- Winner search: scan from ptr upward, wrapping 7->0; the first asserted req bit wins. After a grant to k, ptr = (k+1) mod 8.
- States:
  - IDLE: if req != 0 at edge t, then from cycle t+1 gnt = onehot(winner) and state goes to GRANT. If req == 0, stay in IDLE. Latency is 1 cycle from request to grant.
  - GRANT, owner still requesting (req[owner]=1): hold the grant; hold_cnt increments.
  - GRANT, owner releases (req[owner]=0): at the next cycle the grant goes straight to the next winner, with no idle bubble. The owner is excluded from this search: ptr is already owner+1, and req[owner]=0. If no other request is pending, go to IDLE with gnt=0.
- Requests from non-owners never disturb the current grant, except through timeout.
- A requester dropping req while not granted is simply skipped.
- Simultaneous release by the owner and a new request from any other requester: the new requester is granted the next cycle if it is first from ptr.
- A single requester holding req indefinitely keeps the grant; without the macro, other requesters starve until it releases.
- hold_cnt:
  - Resets to 0 on every new grant.
  - Increments each GRANT cycle while the owner holds.
  - Saturates at MAX_HOLD-1.
- gnt_idx is held at 0 when idle. Downstream must qualify it with gnt_valid.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - When hold_cnt == MAX_HOLD-1, the owner still requests, and at least one other req bit is set, the next cycle grants the next winner from ptr.
  - preempt=1 for exactly that cycle, and hold_cnt resets.
  - If no other requester is pending, the owner keeps the grant, hold_cnt stays saturated, and preemption fires as soon as another request appears.
  - A preempted owner re-competes normally and rejoins after the others are served.
- Not defined:
  - No counter logic exists; preempt is tied to 0.
  - The grant is held until release.

Test Plan:
1. Reset, then req=8'h00 for 5 cycles -> gnt=0, gnt_valid=0, gnt_idx=0, preempt=0 throughout.
2. req=8'h01 at cycle 0 -> gnt=8'h01, gnt_idx=0 from cycle 1. Drop req at cycle 4 -> gnt=0 at cycle 5.
3. req=8'hFF held, each owner releasing after 2 cycles and re-requesting -> owners in order 0,1,2,...,7,0 with no idle gap between grants.
4. Owner 5 holds, req=8'h21 -> grant stays at 5. Release 5 -> next grant is 0 (wrap from ptr=6), one cycle later.
5. ARB_TIMEOUT_EN, MAX_HOLD=4: req[2] held, req[6] asserted at cycle 1 -> gnt=8'h04 for cycles 1..4, then gnt=8'h40 and preempt=1 at cycle 5. Without the macro, gnt stays at 8'h04.
6. rst_n=0 during an active grant to 3 -> next cycle all outputs 0 and ptr=0. With req=8'h88 after reset, index 3 wins first.

Source files
------------

// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle between 8 requesting agents and the round-robin arbiter.
// master: the requester side (drives req); slave: the arbiter (drives grants).
interface rr_arbiter_8_if;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       preempt;

  modport master (output req, input gnt, input gnt_idx, input gnt_valid, input preempt);
  modport slave  (input req, output gnt, output gnt_idx, output gnt_valid, output preempt);
endinterface

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters with a registered owner index decoded
// to a one-hot grant. The owner keeps the grant until it drops its request and
// the grant then moves directly to the next requester from ptr (no idle bubble).
// Optional feature macro: ARB_TIMEOUT_EN -- adds a hold counter that forces a
// handover after MAX_HOLD consecutive grant cycles when someone else is waiting,
// signalled by a one-cycle preempt pulse. Without it preempt is tied low.
module rr_arbiter_8 #(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 8
) (
  input logic           clk,
  input logic           rst_n,
  rr_arbiter_8_if.slave bus
);

  // Reject configurations the hold counter cannot represent.
  if (MAX_HOLD < 2 || MAX_HOLD > 255 || MAX_HOLD > (2 ** HOLD_W) - 1) begin : g_bad_cfg
    $error("rr_arbiter_8: MAX_HOLD must be 2..255 and fit in HOLD_W bits");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_reg, state_next;
  logic [2:0] owner_reg, owner_next;
  logic [2:0] ptr_reg, ptr_next;
  logic       preempt_reg, preempt_next;
  logic       new_grant;

  logic [2:0] win_idx;
  logic       win_found;
  logic [2:0] cand;
  logic       owner_req;
  logic       others_req;
  logic       timeout;
  logic [7:0] gnt_dec;

  assign owner_req  = bus.req[owner_reg];
  assign others_req = |(bus.req & ~(8'b1 << owner_reg));

`ifdef ARB_TIMEOUT_EN
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;

  // Hold counter: cleared on each new grant or when idle, counts while the
  // owner holds and saturates at MAX_HOLD-1 so a late competitor still preempts.
  always_comb begin
    hold_cnt_next = hold_cnt_reg;
    if (new_grant || state_next == IDLE) begin
      hold_cnt_next = '0;
    end else if (state_reg == GRANT && hold_cnt_reg != HOLD_LAST) begin
      hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
    end
  end

  // Hold counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) hold_cnt_reg <= '0;
    else        hold_cnt_reg <= hold_cnt_next;
  end

  assign timeout = (hold_cnt_reg == HOLD_LAST) && owner_req && others_req;
`else
  assign timeout = 1'b0;
`endif

  // Winner search: first asserted request scanning upward from ptr, wrapping 7->0.
  always_comb begin
    win_idx   = 3'd0;
    win_found = 1'b0;
    cand      = 3'd0;
    for (int i = 0; i < 8; i++) begin
      cand = ptr_reg + 3'(i);
      if (!win_found && bus.req[cand]) begin
        win_idx   = cand;
        win_found = 1'b1;
      end
    end
  end

  // Next-state logic: grant from idle, hold, hand over on release or timeout.
  always_comb begin
    state_next   = state_reg;
    owner_next   = owner_reg;
    ptr_next     = ptr_reg;
    preempt_next = 1'b0;
    new_grant    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (win_found) begin
          state_next = GRANT;
          owner_next = win_idx;
          ptr_next   = win_idx + 3'd1;
          new_grant  = 1'b1;
        end
      end
      GRANT: begin
        if (owner_req && !timeout) begin
          state_next = GRANT;
        end else if (win_found) begin
          // ptr is already owner+1, so the current owner is only reached after
          // every other requester; on release its own req bit is low anyway.
          state_next   = GRANT;
          owner_next   = win_idx;
          ptr_next     = win_idx + 3'd1;
          new_grant    = 1'b1;
          preempt_next = timeout;
        end else begin
          state_next = IDLE;
          owner_next = 3'd0;
        end
      end
      default: begin
        state_next = IDLE;
        owner_next = 3'd0;
      end
    endcase
  end

  // State register: owner index, search pointer and preempt pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      owner_reg   <= 3'd0;
      ptr_reg     <= 3'd0;
      preempt_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      owner_reg   <= owner_next;
      ptr_reg     <= ptr_next;
      preempt_reg <= preempt_next;
    end
  end

  // One-hot decode of the registered owner, gated by the grant state.
  for (genvar gi = 0; gi < 8; gi++) begin : g_dec
    assign gnt_dec[gi] = (state_reg == GRANT) && (owner_reg == 3'(gi));
  end

  // Output logic: everything derives directly from registered state.
  always_comb begin
    bus.gnt       = gnt_dec;
    bus.gnt_idx   = owner_reg;
    bus.gnt_valid = (state_reg == GRANT);
    bus.preempt   = preempt_reg;
  end

endmodule
